// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: drives the I-memory read, gates PC advance,
// owns the IF/ID register and resolves J/JAL/BEQ/BNE redirects for the pc block.
module fetch_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] imemaddr,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        stall,
    input  logic        flush,
    input  logic        equal,
    output logic        iREN,
    output logic        pcEN,
    output logic        branchmux,
    output logic        jumpmux,
    output logic [25:0] imm26,
    output logic [31:0] immext,
    output logic [31:0] instr,
    output logic [31:0] npc,
    output logic        ivalid,
    output logic        halt,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } state_e;

    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_HALT = 6'b111111;

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] npc_q, npc_d;
    logic        ivalid_q, ivalid_d;
    logic        halt_q, halt_d;

    logic        accept;
    logic        iren_c;
    logic        halt_seen;
    logic        live;
    logic [5:0]  opcode;

    assign opcode    = instr_q[31:26];
    assign halt_seen = ivalid_q && (opcode == OP_HALT);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            instr_q  <= 32'd0;
            npc_q    <= 32'd0;
            ivalid_q <= 1'b0;
            halt_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            npc_q    <= npc_d;
            ivalid_q <= ivalid_d;
            halt_q   <= halt_d;
        end
    end

    // Fetch handshake: pcEN (= accept) is high only in a FETCH cycle that sees
    // ihit with neither stall nor flush; the PC and IF/ID both move on that edge.
    // flush beats stall, stall beats ihit; a plain miss loads a bubble.
    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        npc_d    = npc_q;
        ivalid_d = ivalid_q;
        halt_d   = halt_q;
        iren_c   = 1'b0;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                iren_c = 1'b1;
                if (flush) begin
                    instr_d  = 32'd0;
                    ivalid_d = 1'b0;
                end else if (stall) begin
                    instr_d  = instr_q;
                end else if (ihit) begin
                    accept   = 1'b1;
                    instr_d  = imemload;
                    npc_d    = imemaddr + 32'd4;
                    ivalid_d = 1'b1;
                end else begin
                    instr_d  = 32'd0;
                    ivalid_d = 1'b0;
                end
                if (halt_seen) begin
                    state_d = HALTED;
                    halt_d  = 1'b1;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (RST) begin
            iren_c = 1'b0;
            accept = 1'b0;
        end
    end

    // Redirect decode reads the held IF/ID word, so the mux stays up across
    // stalls and drops naturally once the delay slot is captured.
    assign live      = !RST && (state_q == FETCH) && ivalid_q && !flush;
    assign jumpmux   = live && ((opcode == OP_J) || (opcode == OP_JAL));
    assign branchmux = live && (((opcode == OP_BEQ) && equal) ||
                                ((opcode == OP_BNE) && !equal));

    assign iREN        = iren_c;
    assign pcEN        = accept;
    assign imm26       = instr_q[25:0];
    assign immext      = {{16{instr_q[15]}}, instr_q[15:0]};
    assign instr       = instr_q;
    assign npc         = npc_q;
    assign ivalid      = ivalid_q;
    assign halt        = halt_q;
    assign dbg_state_o = state_q;

endmodule
